// File: rtl/mvm_pkg.sv
// Shared types and sizing helpers for the skew-scheduled matrix-vector multiplier.
package mvm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int acc_width(input int dw, input int cols);
        return 2 * dw + $clog2(cols);
    endfunction

    // Last RUN cycle index: the bottom row finishes its COLS products here.
    function automatic int t_last(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/mvm_fifo.sv
// Synchronous FIFO with registered read data and a synchronous flush.
module mvm_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_wren,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rden,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_data;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == C_FULL);
    assign o_empty = (r_count == '0);
    assign o_data  = r_data;
    assign w_wr    = i_wren && !o_full;
    assign w_rd    = i_rden && !o_empty;

    always_ff @(posedge clk) begin
        if (w_wr && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + PW'(1);
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + PW'(1);
                r_data   <= r_mem[r_rd_ptr];
            end
            if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
            else if (w_rd && !w_wr) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/mat_vec_mult_sys.sv
// y = A*b with per-row A FIFOs, a b FIFO and a b shift chain that skews row r by r cycles.
module mat_vec_mult_sys
    import mvm_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, COLS),
    parameter int SIGNED     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [ROWS-1:0]            a_wren,
    input  logic [ROWS*DATA_WIDTH-1:0] a_data,
    input  logic                       b_wren,
    input  logic [DATA_WIDTH-1:0]      b_data,
    input  logic                       start,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [ROWS*ACC_WIDTH-1:0]  out,
    output logic                       err
);
    localparam int T_LAST = t_last(ROWS, COLS);
    localparam int TW     = $clog2(T_LAST + 1);
    localparam int PW     = 2 * DATA_WIDTH;
    localparam logic [TW-1:0] T_END = TW'(T_LAST);

    state_t          r_state;
    logic [TW-1:0]   r_t;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic                  w_idle;
    logic                  w_run;
    logic                  w_start_ok;
    logic                  w_drop;
    logic [ROWS-1:0]       w_a_wr;
    logic [ROWS-1:0]       w_a_rden;
    logic [ROWS-1:0]       w_a_full;
    logic [ROWS-1:0]       w_a_empty;
    logic [DATA_WIDTH-1:0] w_a_out  [ROWS];
    logic [DATA_WIDTH-1:0] w_b_pipe [ROWS];
    logic [DATA_WIDTH-1:0] w_b_out;
    logic                  w_b_rden;
    logic                  w_b_full;
    logic                  w_b_empty;

    assign w_idle     = (r_state == IDLE);
    assign w_run      = (r_state == RUN);
    assign ready      = w_idle && (&w_a_full) && w_b_full;
    assign w_start_ok = start && ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign w_a_wr     = a_wren & {ROWS{w_idle && !clr}};
    assign w_b_rden   = w_run && (r_t < TW'(COLS)) && !w_b_empty;
    assign w_drop     = (|(a_wren & (w_a_full | {ROWS{!w_idle}}))) || (b_wren && (w_b_full || !w_idle));
    assign w_b_pipe[0] = w_b_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (clr) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err  <= r_err | w_drop;
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_start_ok) begin
                    r_state <= RUN;
                    r_t     <= '0;
                    r_busy  <= 1'b1;
                end
                RUN: if (r_t == T_END) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_t <= r_t + TW'(1);
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    mvm_fifo #(.DEPTH(COLS), .WIDTH(DATA_WIDTH)) u_b_fifo (
        .clk(clk), .rst_n(rst_n), .i_flush(clr),
        .i_wren(b_wren && w_idle && !clr), .i_wdata(b_data), .i_rden(w_b_rden),
        .o_data(w_b_out), .o_full(w_b_full), .o_empty(w_b_empty)
    );

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [ACC_WIDTH-1:0] r_acc;
        logic [PW-1:0]        w_prod;
        logic [ACC_WIDTH-1:0] w_prod_ext;
        logic                 w_mac_en;

        // Window tests use a wrapping subtract: t<r wraps above COLS because 2^TW > T_LAST.
        assign w_a_rden[r] = w_run && ((r_t - TW'(r)) < TW'(COLS)) && !w_a_empty[r];
        assign w_mac_en    = w_run && ((r_t - TW'(r + 1)) < TW'(COLS));

        mvm_fifo #(.DEPTH(COLS), .WIDTH(DATA_WIDTH)) u_a_fifo (
            .clk(clk), .rst_n(rst_n), .i_flush(clr),
            .i_wren(w_a_wr[r]), .i_wdata(a_data[r*DATA_WIDTH +: DATA_WIDTH]), .i_rden(w_a_rden[r]),
            .o_data(w_a_out[r]), .o_full(w_a_full[r]), .o_empty(w_a_empty[r])
        );

        if (r > 0) begin : g_shift
            logic [DATA_WIDTH-1:0] r_b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     r_b_q <= '0;
                else if (clr)   r_b_q <= '0;
                else if (w_run) r_b_q <= w_b_pipe[r-1];
            end
            assign w_b_pipe[r] = r_b_q;
        end

        if (SIGNED != 0) begin : g_signed
            assign w_prod     = PW'($signed(w_a_out[r])) * PW'($signed(w_b_pipe[r]));
            assign w_prod_ext = ACC_WIDTH'($signed(w_prod));
        end else begin : g_unsigned
            assign w_prod     = PW'(w_a_out[r]) * PW'(w_b_pipe[r]);
            assign w_prod_ext = ACC_WIDTH'(w_prod);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)          r_acc <= '0;
            else if (clr)        r_acc <= '0;
            else if (w_start_ok) r_acc <= '0;
            else if (w_mac_en)   r_acc <= r_acc + w_prod_ext;
        end

        assign out[r*ACC_WIDTH +: ACC_WIDTH] = r_acc;
    end

endmodule

// File: tb/tb_mat_vec_mult_sys.sv
// Directed bench: 8x8 unsigned and signed instances share stimulus; a 4x3 instance runs alone.
module tb_mat_vec_mult_sys;
    localparam int AW  = 19;   // 2*8 + clog2(8)
    localparam int AWS = 18;   // 2*8 + clog2(3)

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        clr = 1'b0, start = 1'b0, b_wren = 1'b0;
    logic [7:0]  a_wren = '0;
    logic [63:0] a_data = '0;
    logic [7:0]  b_data = '0;
    logic        ready_u, busy_u, done_u, err_u;
    logic        ready_s, busy_s, done_s, err_s;
    logic [8*AW-1:0] out_u, out_s;

    logic        s_clr = 1'b0, s_start = 1'b0, s_b_wren = 1'b0;
    logic [3:0]  s_a_wren = '0;
    logic [31:0] s_a_data = '0;
    logic [7:0]  s_b_data = '0;
    logic        s_ready, s_busy, s_done, s_err;
    logic [4*AWS-1:0] s_out;

    logic [7:0] m_a [8][8];
    logic [7:0] m_b [8];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mat_vec_mult_sys #(.ROWS(8), .COLS(8), .DATA_WIDTH(8), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .a_wren(a_wren), .a_data(a_data),
        .b_wren(b_wren), .b_data(b_data), .start(start), .ready(ready_u),
        .busy(busy_u), .done(done_u), .out(out_u), .err(err_u));

    mat_vec_mult_sys #(.ROWS(8), .COLS(8), .DATA_WIDTH(8), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .a_wren(a_wren), .a_data(a_data),
        .b_wren(b_wren), .b_data(b_data), .start(start), .ready(ready_s),
        .busy(busy_s), .done(done_s), .out(out_s), .err(err_s));

    mat_vec_mult_sys #(.ROWS(4), .COLS(3), .DATA_WIDTH(8), .SIGNED(0)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .a_wren(s_a_wren), .a_data(s_a_data),
        .b_wren(s_b_wren), .b_data(s_b_data), .start(s_start), .ready(s_ready),
        .busy(s_busy), .done(s_done), .out(s_out), .err(s_err));

    task tick;
        @(posedge clk);
        #1;
    endtask

    task set_identity(input int b0);
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) m_a[r][k] = (r == k) ? 8'd1 : 8'd0;
            m_b[r] = 8'(b0 + r);
        end
    endtask

    task load_big;
        for (int k = 0; k < 8; k++) begin
            a_wren = 8'hFF;
            for (int r = 0; r < 8; r++) a_data[r*8 +: 8] = m_a[r][k];
            b_wren = 1'b1;
            b_data = m_b[k];
            tick;
        end
        a_wren = '0;
        b_wren = 1'b0;
    endtask

    task automatic run_big(input bit wr_mid, output int lat, output int bcnt);
        start = 1'b1;
        tick;
        start = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (done_u !== 1'b1 && lat < 60) begin
            if (busy_u === 1'b1) bcnt++;
            if (wr_mid && lat == 3) begin a_wren = 8'hFF; b_wren = 1'b1; end
            else begin a_wren = '0; b_wren = 1'b0; end
            tick;
            lat++;
        end
        a_wren = '0;
        b_wren = 1'b0;
    endtask

    task test_reset;
        rst_n = 1'b0;
        tick; tick;
        n_tests++; if (ready_u !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready_u); end
        n_tests++; if (busy_u !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_u); end
        n_tests++; if (done_u !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_u); end
        n_tests++; if (err_u !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_u); end
        n_tests++; if (out_u !== '0) begin n_fail++; $display("FAIL reset_out got=%h exp=0", out_u); end
        n_tests++; if (s_out !== '0 || s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_small got out=%h ready=%b exp 0/0", s_out, s_ready); end
        rst_n = 1'b1;
        tick;
    endtask

    task test_identity;
        int lat, bcnt;
        set_identity(1);
        load_big;
        n_tests++; if (ready_u !== 1'b1) begin n_fail++; $display("FAIL ident_ready got=%b exp=1", ready_u); end
        run_big(1'b0, lat, bcnt);
        n_tests++; if (lat != 17) begin n_fail++; $display("FAIL ident_latency got=%0d exp=17", lat); end
        n_tests++; if (bcnt != 16) begin n_fail++; $display("FAIL ident_busy_cycles got=%0d exp=16", bcnt); end
        for (int r = 0; r < 8; r++) begin
            n_tests++;
            if (out_u[r*AW +: AW] !== AW'(r + 1)) begin
                n_fail++; $display("FAIL ident_out[%0d] got=%0d exp=%0d", r, out_u[r*AW +: AW], r + 1);
            end
        end
        tick;
        n_tests++; if (done_u !== 1'b0) begin n_fail++; $display("FAIL ident_done_pulse got=%b exp=0", done_u); end
        n_tests++; if (ready_u !== 1'b0) begin n_fail++; $display("FAIL ident_ready_after got=%b exp=0", ready_u); end
        n_tests++; if (out_u[7*AW +: AW] !== AW'(8)) begin n_fail++; $display("FAIL ident_out_held got=%0d exp=8", out_u[7*AW +: AW]); end
        n_tests++; if (err_u !== 1'b0) begin n_fail++; $display("FAIL ident_err got=%b exp=0", err_u); end
    endtask

    task test_max_unsigned;
        int lat, bcnt;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) m_a[r][k] = 8'hFF;
            m_b[r] = 8'hFF;
        end
        load_big;
        run_big(1'b0, lat, bcnt);
        for (int r = 0; r < 8; r++) begin
            n_tests++;
            if (out_u[r*AW +: AW] !== AW'(520200)) begin
                n_fail++; $display("FAIL max_out[%0d] got=%0d exp=520200", r, out_u[r*AW +: AW]);
            end
        end
        n_tests++; if (err_u !== 1'b0) begin n_fail++; $display("FAIL max_err got=%b exp=0", err_u); end
        tick;
    endtask

    task test_signed;
        int lat, bcnt;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) m_a[r][k] = 8'h80;
            m_b[r] = 8'h80;
        end
        load_big;
        run_big(1'b0, lat, bcnt);
        n_tests++; if (done_s !== 1'b1) begin n_fail++; $display("FAIL signed_done got=%b exp=1", done_s); end
        for (int r = 0; r < 8; r++) begin
            n_tests++;
            if (out_s[r*AW +: AW] !== AW'(131072)) begin
                n_fail++; $display("FAIL signed_min_out[%0d] got=%0d exp=131072", r, out_s[r*AW +: AW]);
            end
        end
        tick;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) m_a[r][k] = (r == 0) ? 8'h7F : 8'h00;
            m_b[r] = 8'hFF;
        end
        load_big;
        run_big(1'b0, lat, bcnt);
        n_tests++; if (out_s[0 +: AW] !== AW'(-1016)) begin n_fail++; $display("FAIL signed_neg_out0 got=%h exp=%h", out_s[0 +: AW], AW'(-1016)); end
        n_tests++; if (out_s[AW +: AW] !== AW'(0)) begin n_fail++; $display("FAIL signed_neg_out1 got=%0d exp=0", out_s[AW +: AW]); end
        n_tests++; if (out_u[0 +: AW] !== AW'(259080)) begin n_fail++; $display("FAIL unsigned_127x255 got=%0d exp=259080", out_u[0 +: AW]); end
        tick;
    endtask

    task test_partial_load;
        int lat, bcnt;
        set_identity(1);
        for (int k = 0; k < 8; k++) begin
            a_wren = (k == 7) ? 8'hF7 : 8'hFF;
            for (int r = 0; r < 8; r++) a_data[r*8 +: 8] = m_a[r][k];
            b_wren = 1'b1;
            b_data = m_b[k];
            tick;
        end
        a_wren = '0; b_wren = 1'b0;
        n_tests++; if (ready_u !== 1'b0) begin n_fail++; $display("FAIL partial_ready got=%b exp=0", ready_u); end
        start = 1'b1; tick; start = 1'b0; tick;
        n_tests++; if (busy_u !== 1'b0) begin n_fail++; $display("FAIL partial_start_ignored busy got=%b exp=0", busy_u); end
        n_tests++; if (err_u !== 1'b0) begin n_fail++; $display("FAIL partial_err got=%b exp=0", err_u); end
        a_wren = 8'h08; a_data[3*8 +: 8] = m_a[3][7]; tick; a_wren = '0;
        n_tests++; if (ready_u !== 1'b1) begin n_fail++; $display("FAIL partial_ready_full got=%b exp=1", ready_u); end
        run_big(1'b0, lat, bcnt);
        n_tests++; if (lat != 17) begin n_fail++; $display("FAIL partial_latency got=%0d exp=17", lat); end
        n_tests++; if (out_u[3*AW +: AW] !== AW'(4)) begin n_fail++; $display("FAIL partial_out3 got=%0d exp=4", out_u[3*AW +: AW]); end
        tick;
    endtask

    task test_clr;
        int lat, bcnt, dcnt;
        set_identity(10);
        load_big;
        start = 1'b1; tick; start = 1'b0;   // now RUN t=0
        tick; tick;                          // t=2
        b_wren = 1'b1; tick; b_wren = 1'b0;  // t=3, dropped write
        n_tests++; if (err_u !== 1'b1) begin n_fail++; $display("FAIL clr_err_set got=%b exp=1", err_u); end
        tick; tick;                          // t=5
        clr = 1'b1; a_wren = 8'hFF; b_wren = 1'b1;
        tick;
        clr = 1'b0; a_wren = '0; b_wren = 1'b0;
        n_tests++; if (busy_u !== 1'b0) begin n_fail++; $display("FAIL clr_busy got=%b exp=0", busy_u); end
        n_tests++; if (err_u !== 1'b0) begin n_fail++; $display("FAIL clr_err got=%b exp=0", err_u); end
        n_tests++; if (out_u !== '0) begin n_fail++; $display("FAIL clr_out got=%h exp=0", out_u); end
        n_tests++; if (ready_u !== 1'b0) begin n_fail++; $display("FAIL clr_ready got=%b exp=0", ready_u); end
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done_u === 1'b1) dcnt++;
            tick;
        end
        n_tests++; if (dcnt != 0) begin n_fail++; $display("FAIL clr_no_done got=%0d exp=0", dcnt); end
        load_big;
        n_tests++; if (ready_u !== 1'b1 || err_u !== 1'b0) begin n_fail++; $display("FAIL clr_reload got ready=%b err=%b exp 1/0", ready_u, err_u); end
        run_big(1'b0, lat, bcnt);
        for (int r = 0; r < 8; r++) begin
            n_tests++;
            if (out_u[r*AW +: AW] !== AW'(10 + r)) begin
                n_fail++; $display("FAIL clr_rerun_out[%0d] got=%0d exp=%0d", r, out_u[r*AW +: AW], 10 + r);
            end
        end
        tick;
    endtask

    task test_overflow;
        int lat, bcnt;
        set_identity(1);
        load_big;
        a_wren = 8'h01; a_data[7:0] = 8'd99; tick; a_wren = '0;
        n_tests++; if (err_u !== 1'b1) begin n_fail++; $display("FAIL ovf_err got=%b exp=1", err_u); end
        n_tests++; if (ready_u !== 1'b1) begin n_fail++; $display("FAIL ovf_ready got=%b exp=1", ready_u); end
        run_big(1'b1, lat, bcnt);
        n_tests++; if (lat != 17) begin n_fail++; $display("FAIL ovf_latency got=%0d exp=17", lat); end
        n_tests++; if (err_u !== 1'b1) begin n_fail++; $display("FAIL ovf_err_sticky got=%b exp=1", err_u); end
        for (int r = 0; r < 8; r++) begin
            n_tests++;
            if (out_u[r*AW +: AW] !== AW'(r + 1)) begin
                n_fail++; $display("FAIL ovf_out[%0d] got=%0d exp=%0d", r, out_u[r*AW +: AW], r + 1);
            end
        end
        tick;
    endtask

    task test_small;
        int lat, bcnt;
        logic [7:0] sb [3];
        sb[0] = 8'd1; sb[1] = 8'd2; sb[2] = 8'd3;
        for (int k = 0; k < 3; k++) begin
            s_a_wren = 4'hF;
            for (int r = 0; r < 4; r++) s_a_data[r*8 +: 8] = (r == k) ? 8'd1 : 8'd0;
            s_b_wren = 1'b1;
            s_b_data = sb[k];
            tick;
        end
        s_a_wren = '0; s_b_wren = 1'b0;
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL small_ready got=%b exp=1", s_ready); end
        s_start = 1'b1; tick; s_start = 1'b0;
        lat = 1; bcnt = 0;
        while (s_done !== 1'b1 && lat < 40) begin
            if (s_busy === 1'b1) bcnt++;
            tick;
            lat++;
        end
        n_tests++; if (lat != 8) begin n_fail++; $display("FAIL small_latency got=%0d exp=8", lat); end
        n_tests++; if (bcnt != 7) begin n_fail++; $display("FAIL small_busy_cycles got=%0d exp=7", bcnt); end
        for (int r = 0; r < 4; r++) begin
            n_tests++;
            if (s_out[r*AWS +: AWS] !== AWS'((r < 3) ? r + 1 : 0)) begin
                n_fail++; $display("FAIL small_out[%0d] got=%0d exp=%0d", r, s_out[r*AWS +: AWS], (r < 3) ? r + 1 : 0);
            end
        end
        n_tests++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL small_err got=%b exp=0", s_err); end
        tick;
    endtask

    task test_async_reset;
        set_identity(1);
        load_big;
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        n_tests++; if (busy_u !== 1'b1) begin n_fail++; $display("FAIL arst_busy_before got=%b exp=1", busy_u); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (busy_u !== 1'b0 || err_u !== 1'b0) begin n_fail++; $display("FAIL arst_immediate got busy=%b err=%b exp 0/0", busy_u, err_u); end
        tick;
        rst_n = 1'b1;
        tick;
        n_tests++; if (ready_u !== 1'b0 || out_u !== '0) begin n_fail++; $display("FAIL arst_state got ready=%b out=%h exp 0/0", ready_u, out_u); end
    endtask

    initial begin
        test_reset;
        test_identity;
        test_max_unsigned;
        test_signed;
        test_partial_load;
        test_clr;
        test_overflow;
        test_small;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mat_vec_mult_sys.md
Name: mat_vec_mult_sys

Overview:
- Parametrised, skew-scheduled matrix-vector multiplier: y = A·b, A is ROWS×COLS, b is COLS×1, y is ROWS×1.
- Per-row input FIFOs for A and one FIFO for b are filled by the host.
- On start, rows are read with a one-cycle-per-row stagger; b elements travel a shift chain so each row MAC sees a[r][k] and b[k] together.
- Adds signed mode, a done/ready handshake, sync abort and an error flag. It is the next generation of the 8×8 unsigned multiplier.

Parameters:
ROWS, 8, number of matrix rows, MAC lanes and A FIFOs (≥1)
COLS, 8, vector length and depth of every FIFO (≥1)
DATA_WIDTH, 8, operand width
ACC_WIDTH, 2*DATA_WIDTH+$clog2(COLS), accumulator/output width per row (must be ≥ 2*DATA_WIDTH)
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and results

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  reset, asynchronous, active-low
clr  in  1  sync abort: flush FIFOs, zero accumulators, go IDLE, clear err
a_wren  in  ROWS  per-row A FIFO write enable
a_data  in  ROWS*DATA_WIDTH  packed A write data; row r at [r*DATA_WIDTH +: DATA_WIDTH]
b_wren  in  1  b FIFO write enable
b_data  in  DATA_WIDTH  b write data
start  in  1  begin computation; honoured only while ready=1
ready  out  1  state IDLE and all ROWS+1 FIFOs hold COLS entries
busy  out  1  state RUN
done  out  1  one-cycle pulse when out is final
out  out  ROWS*ACC_WIDTH  packed results; row r at [r*ACC_WIDTH +: ACC_WIDTH]
err  out  1  sticky: write dropped (FIFO full, or state≠IDLE)

Behaviour:
- Reset values: state IDLE; FIFOs empty; accumulators, out, done, busy, err all 0. ready=0.
- FIFOs: depth COLS, registered read, data valid the cycle after rden. A write is accepted only when state=IDLE and that FIFO is not full. Any other write attempt is dropped and sets err.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start&ready. The same edge zeroes all accumulators and t.
  - RUN: cycle counter t runs 0..ROWS+COLS-1. RUN→DONE when t=ROWS+COLS-1.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start while ready=0, or while in RUN/DONE: ignored, no error.
- Read schedule, at RUN cycle t:
  - b FIFO rden when t<COLS.
  - A row r rden when r≤t<r+COLS.
  - b_pipe[0] takes the b FIFO output; b_pipe[r] takes b_pipe[r-1] each RUN cycle.
  - Row r MAC is enabled at cycles r+1..r+COLS and accumulates a_out[r]*b_pipe[r]. This gives a[r][k]*b[k] for k=0..COLS-1 in order.
- Latency: done is high the (ROWS+COLS+1)th cycle after the start-accepting edge. For 8×8 this is 17.
- out holds the accumulator values. They are final when done=1 and held until the next accepted start or clr. Mid-RUN values are partial and undefined to the consumer.
- Arithmetic:
  - SIGNED=0: zero-extend the product.
  - SIGNED=1: sign-extend the product to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH. Default ACC_WIDTH cannot overflow.
- clr has priority over start and over FSM transitions. If asserted mid-RUN, all FIFOs are emptied, accumulators zeroed, IDLE next cycle, and no done pulse.
- Writes in the same cycle as clr are dropped without setting err.
- After DONE, all FIFOs are empty. ready rises only after a full reload.
- Asynchronous reset mid-RUN: immediate return to reset values.

Decomposition:
- Package mvm_pkg holds:
  - state_t enum {IDLE, RUN, DONE};
  - function acc_width(dw, cols);
  - localparam T_LAST helper.
- One sub-module, mvm_fifo: parametrised sync FIFO (DEPTH, WIDTH) with full/empty, registered o_data and a flush input. It is instantiated ROWS+1 times.
- MAC lanes stay inline in a generate loop.

Test Plan:
- Identity: A=I8, b={1..8}, unsigned → out[r]=r+1; done exactly 17 cycles after start edge; busy high 16 cycles.
- Max unsigned: all A and b =255 → each out=520200; err=0.
- SIGNED=1: all A=-128, b=-128 → out=131072. Then row 0 with A=127 and b=-1 → out[0]=-1016.
- start with one A FIFO holding 7 entries → ready=0, stays IDLE. 8th write → ready=1, and start is then accepted.
- clr at RUN t=5 → no done; the next cycle is IDLE with empty FIFOs, out=0, err=0. A reload and rerun gives the correct result.
- Overflow: write a 9th entry to a full A FIFO, and write during RUN → both dropped, err=1, result unaffected. Repeat the identity check with ROWS=4, COLS=3, ACC_WIDTH default → done 8 cycles after start.
